uart_rx: RTL and testbench

Asynchronous-serial receiver for the UART subsystem, built as the counterpart of the existing UART transmitter. It oversamples the line by a programmable prescale and majority-votes each bit at mid-period. It deserializes 8 data bits LSB first, with optional even/odd parity and one stop bit. It presents the received byte with a one-cycle valid strobe, and flags parity and framing errors.

---
 rtl/uart_rx.sv | 186 ++++++++++++++++++
 tb/tb_uart_rx.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
// uart_rx: oversampling asynchronous-serial receiver.
// 8 data bits LSB first, optional even/odd parity, one stop bit.
// Each bit is majority-voted from three samples around mid-period.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | line idle; a low sample is edge 0 of the start bit
// START  | confirm start bit; a high vote means glitch, back to IDLE
// DATA   | shift 8 voted bits into the frame buffer, LSB first
// PARITY | compare voted parity bit against the frame's expected parity
// STOP   | sample stop bit, publish byte or error strobes at last edge

module uart_rx (
    input  logic       clk,
    input  logic       rst,
    input  logic       RX_IN,
    input  logic [5:0] Prescale,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic [7:0] P_DATA,
    output logic       Data_valid,
    output logic       par_err,
    output logic       stp_err
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    state_t     state_q,      state_d;
    logic [5:0] edge_cnt_q,   edge_cnt_d;
    logic [2:0] bit_cnt_q,    bit_cnt_d;
    logic [5:0] presc_q,      presc_d;
    logic       par_en_q,     par_en_d;
    logic       par_typ_q,    par_typ_d;
    logic [1:0] smp_q,        smp_d;
    logic       bit_val_q,    bit_val_d;
    logic [7:0] shift_q,      shift_d;
    logic       frame_perr_q, frame_perr_d;
    logic [7:0] p_data_q,     p_data_d;
    logic       data_valid_q, data_valid_d;
    logic       par_err_q,    par_err_d;
    logic       stp_err_q,    stp_err_d;

    // Bit-position decode, all relative to the prescale latched for this frame.
    logic [5:0] half_p;
    logic [5:0] last_edge;
    logic       at_last;
    logic       at_smp0;
    logic       at_smp1;
    logic       at_mid;
    logic       vote;

    assign half_p    = {1'b0, presc_q[5:1]};
    assign last_edge = presc_q - 6'd1;
    assign at_last   = (edge_cnt_q == last_edge);
    assign at_smp0   = (edge_cnt_q == (half_p - 6'd2));
    assign at_smp1   = (edge_cnt_q == (half_p - 6'd1));
    assign at_mid    = (edge_cnt_q == half_p);

    // Third sample is the live line at mid-period; two of three wins.
    assign vote = (smp_q[0] & smp_q[1]) | (smp_q[0] & RX_IN) | (smp_q[1] & RX_IN);

    // Next-state, sampling and output-strobe computation.
    always_comb begin
        state_d      = state_q;
        edge_cnt_d   = edge_cnt_q;
        bit_cnt_d    = bit_cnt_q;
        presc_d      = presc_q;
        par_en_d     = par_en_q;
        par_typ_d    = par_typ_q;
        smp_d        = smp_q;
        bit_val_d    = bit_val_q;
        shift_d      = shift_q;
        frame_perr_d = frame_perr_q;
        p_data_d     = p_data_q;
        data_valid_d = 1'b0;
        par_err_d    = 1'b0;
        stp_err_d    = 1'b0;

        if (state_q == IDLE) begin
            edge_cnt_d = 6'd0;
            if (!RX_IN) begin
                // Detection cycle already counts as edge 0 of the start bit.
                state_d      = START;
                edge_cnt_d   = 6'd1;
                bit_cnt_d    = 3'd0;
                presc_d      = Prescale;
                par_en_d     = PAR_EN;
                par_typ_d    = PAR_TYP;
                frame_perr_d = 1'b0;
            end
        end else begin
            edge_cnt_d = at_last ? 6'd0 : edge_cnt_q + 6'd1;

            if (at_smp0) begin
                smp_d[0] = RX_IN;
            end
            if (at_smp1) begin
                smp_d[1] = RX_IN;
            end
            if (at_mid) begin
                bit_val_d = vote;
                if (state_q == DATA) begin
                    shift_d[bit_cnt_q] = vote;
                end
            end

            if (at_last) begin
                case (state_q)
                    START: begin
                        state_d   = bit_val_q ? IDLE : DATA;
                        bit_cnt_d = 3'd0;
                    end
                    DATA: begin
                        if (bit_cnt_q == 3'd7) begin
                            state_d = par_en_q ? PARITY : STOP;
                        end
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                    PARITY: begin
                        frame_perr_d = bit_val_q ^ (^shift_q) ^ par_typ_q;
                        state_d      = STOP;
                    end
                    STOP: begin
                        state_d      = IDLE;
                        stp_err_d    = ~bit_val_q;
                        par_err_d    = frame_perr_q;
                        data_valid_d = bit_val_q & ~frame_perr_q;
                        if (bit_val_q && !frame_perr_q) begin
                            p_data_d = shift_q;
                        end
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
        end
    end

    // State and output registers; reset clears outputs immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            edge_cnt_q   <= 6'd0;
            bit_cnt_q    <= 3'd0;
            presc_q      <= 6'd8;
            par_en_q     <= 1'b0;
            par_typ_q    <= 1'b0;
            smp_q        <= 2'b11;
            bit_val_q    <= 1'b1;
            shift_q      <= 8'h00;
            frame_perr_q <= 1'b0;
            p_data_q     <= 8'h00;
            data_valid_q <= 1'b0;
            par_err_q    <= 1'b0;
            stp_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            edge_cnt_q   <= edge_cnt_d;
            bit_cnt_q    <= bit_cnt_d;
            presc_q      <= presc_d;
            par_en_q     <= par_en_d;
            par_typ_q    <= par_typ_d;
            smp_q        <= smp_d;
            bit_val_q    <= bit_val_d;
            shift_q      <= shift_d;
            frame_perr_q <= frame_perr_d;
            p_data_q     <= p_data_d;
            data_valid_q <= data_valid_d;
            par_err_q    <= par_err_d;
            stp_err_q    <= stp_err_d;
        end
    end

    assign P_DATA     = p_data_q;
    assign Data_valid = data_valid_q;
    assign par_err    = par_err_q;
    assign stp_err    = stp_err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of directed frames, hand-written corner
// sequences (glitch, back-to-back, mid-frame reset) and random frames
// checked against a frame-level reference model.

module tb_uart_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       RX_IN;
    logic [5:0] Prescale;
    logic       PAR_EN;
    logic       PAR_TYP;
    logic [7:0] P_DATA;
    logic       Data_valid;
    logic       par_err;
    logic       stp_err;

    uart_rx dut (
        .clk        (clk),
        .rst        (rst),
        .RX_IN      (RX_IN),
        .Prescale   (Prescale),
        .PAR_EN     (PAR_EN),
        .PAR_TYP    (PAR_TYP),
        .P_DATA     (P_DATA),
        .Data_valid (Data_valid),
        .par_err    (par_err),
        .stp_err    (stp_err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         cyc;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } ev_t;

    ev_t evq[$];
    ev_t expq[$];

    // Record every strobe cycle, sampled mid-cycle.
    always @(negedge clk) begin : mon
        ev_t e;
        if (Data_valid || par_err || stp_err) begin
            e.cyc = cyc;
            e.dv  = Data_valid;
            e.pe  = par_err;
            e.se  = stp_err;
            e.pd  = P_DATA;
            evq.push_back(e);
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string nm, input int act, input int exp_v);
        total++;
        if (act != exp_v) begin
            bad++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp_v, exp_v);
        end
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input bit b, input int p);
        RX_IN = b;
        wait_cycles(p);
    endtask

    // Drives one full frame; t0 is the cycle number of the start-detection cycle.
    task automatic send_frame(input int p, input bit pen, input bit ptyp, input logic [7:0] d,
                              input bit pbit, input bit sbit, input bit scramble, output int t0);
        int pick;
        Prescale = 6'(p);
        PAR_EN   = pen;
        PAR_TYP  = ptyp;
        t0       = cyc;
        RX_IN    = 1'b0;
        wait_cycles(1);
        if (scramble) begin
            pick     = $urandom_range(0, 2);
            Prescale = 6'(8 << pick);
            PAR_EN   = 1'($urandom);
            PAR_TYP  = 1'($urandom);
        end
        wait_cycles(p - 1);
        for (int i = 0; i < 8; i++) drive_bit(d[i], p);
        if (pen) drive_bit(pbit, p);
        drive_bit(sbit, p);
    endtask

    task automatic expect_one(input string nm, input int t0, input int lat,
                              input bit dv, input bit pe, input bit se, input logic [7:0] pd);
        RX_IN = 1'b1;
        wait_cycles(3);
        chk({nm, " strobe_count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            chk({nm, " latency"}, evq[0].cyc - t0, lat);
            chk({nm, " Data_valid"}, int'(evq[0].dv), int'(dv));
            chk({nm, " par_err"}, int'(evq[0].pe), int'(pe));
            chk({nm, " stp_err"}, int'(evq[0].se), int'(se));
            chk({nm, " P_DATA"}, int'(evq[0].pd), int'(pd));
        end
        evq.delete();
    endtask

    typedef struct {
        int         p;
        bit         pen;
        bit         ptyp;
        logic [7:0] d;
        bit         pbit;
        bit         sbit;
        int         lat;
        bit         dv;
        bit         pe;
        bit         se;
        logic [7:0] pd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        int         t0;
        int         t1;
        int         n;
        int         p;
        int         gap;
        bit         pen;
        bit         ptyp;
        bit         good;
        bit         pbit;
        bit         sbit;
        bit         e_pe;
        bit         e_se;
        bit         e_dv;
        logic [7:0] d;
        logic [7:0] model_pd;
        ev_t        x;

        //            p  pen ptyp d      pbit sbit lat  dv pe se pd
        tbl[0] = '{ 8, 0, 0, 8'hA5, 0, 1,  80, 1, 0, 0, 8'hA5};
        tbl[1] = '{16, 1, 0, 8'h3C, 0, 1, 176, 1, 0, 0, 8'h3C};
        tbl[2] = '{16, 1, 0, 8'h3C, 1, 1, 176, 0, 1, 0, 8'h3C};
        tbl[3] = '{ 8, 1, 1, 8'h01, 0, 0,  88, 0, 0, 1, 8'h3C};
        tbl[4] = '{16, 1, 1, 8'hFF, 1, 1, 176, 1, 0, 0, 8'hFF};
        tbl[5] = '{32, 0, 0, 8'h00, 0, 1, 320, 1, 0, 0, 8'h00};
        tbl[6] = '{ 8, 1, 0, 8'h80, 0, 0,  88, 0, 1, 1, 8'h00};
        tbl[7] = '{ 8, 0, 1, 8'hC3, 0, 1,  80, 1, 0, 0, 8'hC3};

        rst      = 1'b0;
        RX_IN    = 1'b1;
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        PAR_TYP  = 1'b0;
        #2 rst = 1'b1;
        #2;
        chk("reset P_DATA", int'(P_DATA), 0);
        chk("reset Data_valid", int'(Data_valid), 0);
        chk("reset par_err", int'(par_err), 0);
        chk("reset stp_err", int'(stp_err), 0);
        wait_cycles(3);
        rst = 1'b0;
        wait_cycles(3);
        evq.delete();

        // Directed frames from the table.
        for (int i = 0; i < 8; i++) begin
            send_frame(tbl[i].p, tbl[i].pen, tbl[i].ptyp, tbl[i].d, tbl[i].pbit, tbl[i].sbit, 1'b0, t0);
            expect_one($sformatf("vec%0d", i), t0, tbl[i].lat, tbl[i].dv, tbl[i].pe, tbl[i].se, tbl[i].pd);
            wait_cycles(4);
        end

        // Two-cycle glitch at P=32, then a frame as soon as the FSM is back in IDLE.
        Prescale = 6'd32;
        PAR_EN   = 1'b0;
        evq.delete();
        RX_IN = 1'b0;
        wait_cycles(2);
        RX_IN = 1'b1;
        wait_cycles(30);
        chk("glitch strobe_count", evq.size(), 0);
        send_frame(32, 0, 0, 8'h5A, 0, 1, 1'b0, t0);
        expect_one("after_glitch", t0, 320, 1, 0, 0, 8'h5A);
        wait_cycles(4);

        // Back-to-back frames with no idle cycle between them.
        send_frame(8, 0, 0, 8'h11, 0, 1, 1'b0, t0);
        send_frame(8, 0, 0, 8'hEE, 0, 1, 1'b0, t1);
        RX_IN = 1'b1;
        wait_cycles(3);
        chk("b2b strobe_count", evq.size(), 2);
        if (evq.size() >= 2) begin
            chk("b2b first latency", evq[0].cyc - t0, 80);
            chk("b2b spacing", evq[1].cyc - evq[0].cyc, 80);
            chk("b2b second latency", evq[1].cyc - t1, 80);
            chk("b2b data0", int'(evq[0].pd), 8'h11);
            chk("b2b data1", int'(evq[1].pd), 8'hEE);
            chk("b2b valid0", int'(evq[0].dv), 1);
            chk("b2b valid1", int'(evq[1].dv), 1);
        end
        evq.delete();
        wait_cycles(4);

        // Reset asserted during data bit 4 of a 0xFF frame.
        Prescale = 6'd8;
        PAR_EN   = 1'b0;
        RX_IN    = 1'b0;
        wait_cycles(8);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
        RX_IN = 1'b1;
        wait_cycles(3);
        #2 rst = 1'b1;
        #1;
        chk("midrst P_DATA", int'(P_DATA), 0);
        chk("midrst Data_valid", int'(Data_valid), 0);
        chk("midrst par_err", int'(par_err), 0);
        chk("midrst stp_err", int'(stp_err), 0);
        wait_cycles(2);
        rst = 1'b0;
        wait_cycles(50);
        chk("midrst strobe_count", evq.size(), 0);
        evq.delete();
        send_frame(8, 0, 0, 8'h42, 0, 1, 1'b0, t0);
        expect_one("after_rst", t0, 80, 1, 0, 0, 8'h42);
        wait_cycles(4);

        // Random frames against the frame-level model; config inputs wander mid-frame.
        model_pd = 8'h42;
        evq.delete();
        expq.delete();
        for (int k = 0; k < 24; k++) begin
            p    = 8 << $urandom_range(0, 2);
            pen  = 1'($urandom);
            ptyp = 1'($urandom);
            d    = 8'($urandom);
            good = (^d) ^ ptyp;
            pbit = ($urandom_range(0, 3) == 0) ? ~good : good;
            sbit = ($urandom_range(0, 4) != 0);
            gap  = $urandom_range(0, 2);
            send_frame(p, pen, ptyp, d, pbit, sbit, 1'b1, t0);
            e_pe = pen && (pbit != good);
            e_se = !sbit;
            e_dv = !e_pe && !e_se;
            if (e_dv) model_pd = d;
            x.cyc = t0 + (10 + int'(pen)) * p;
            x.dv  = e_dv;
            x.pe  = e_pe;
            x.se  = e_se;
            x.pd  = model_pd;
            expq.push_back(x);
            if (gap > 0) begin
                RX_IN = 1'b1;
                wait_cycles(gap);
            end
        end
        RX_IN = 1'b1;
        wait_cycles(4);
        chk("rand strobe_count", evq.size(), expq.size());
        n = (evq.size() < expq.size()) ? evq.size() : expq.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("rand%0d cycle", i), evq[i].cyc, expq[i].cyc);
            chk($sformatf("rand%0d Data_valid", i), int'(evq[i].dv), int'(expq[i].dv));
            chk($sformatf("rand%0d par_err", i), int'(evq[i].pe), int'(expq[i].pe));
            chk($sformatf("rand%0d stp_err", i), int'(evq[i].se), int'(expq[i].se));
            chk($sformatf("rand%0d P_DATA", i), int'(evq[i].pd), int'(expq[i].pd));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
